bcd_timer: RTL and testbench
============================

# bcd_timer

Parametrised BCD hours:minutes:seconds timer that counts down from a loaded preset, or up from zero to a loaded target. It adds explicit load/start/pause control, preset validation, a one-cycle completion pulse, a sticky expiry flag and optional auto-reload. It sits between the settings/key-handling logic and the 7-segment display driver. Its packed time word uses the display driver's format: BCD digits with 4'hF blank separators.

## Interface

- TICK_DIV, 100000000: clk cycles per one-second tick; must be ≥2.
- HR_MAX, 99: maximum hours value accepted at load (BCD 00–99).
- RELOAD, 0: 1 = restart automatically after completion instead of expiring.

- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset (sampled on rising clk).
- load  in  1  one-cycle pulse; captures preset and mode, enters IDLE.
- preset  in  32  {h10,h1,4'hF,m10,m1,4'hF,s10,s1}; separator nibbles ignored.
- mode  in  1  0 = count down from preset; 1 = count up from 0 to preset. Sampled only on load.
- start  in  1  one-cycle pulse; begin or resume counting.
- pause  in  1  one-cycle pulse; suspend counting.
- time_out  out  32  current count, same packed format, separators always 4'hF.
- running  out  1  high in RUN state.
- done  out  1  one-cycle pulse on completion.
- expired  out  1  sticky completion flag (RELOAD=0 only).
- load_err  out  1  one-cycle pulse when a load is rejected.

## Operation

- States: IDLE, RUN, PAUSE, EXPIRED. Reset → IDLE.
- Reset values: count 0, so time_out = 32'h00F00F00. Also target 0, latched mode 0, prescaler 0, running/done/expired/load_err 0.
- Control priority in one cycle: rst_n > load > pause > start.
- Load, any state:
  - Validation: digit ≤9; s10 and m10 ≤5; hours ≤ HR_MAX.
  - Valid load: target ← preset; count ← preset (mode 0) or 0 (mode 1); latch mode; clear prescaler and expired; → IDLE.
  - Invalid load: load_err=1 for one cycle; all other state unchanged.
- start:
  - IDLE → RUN, prescaler cleared. PAUSE → RUN, prescaler kept.
  - Ignored in RUN and EXPIRED.
  - Ignored if count already terminal (mode 0: count = 0; mode 1: count = target).
- pause: RUN → PAUSE; count and prescaler frozen. Ignored in other states.
- Prescaler: counts 0..TICK_DIV-1 only in RUN; wraps at TICK_DIV-1 and generates a tick.
- On each tick, mode 0: BCD decrement with borrow chain.
  - s1 0→9 borrows s10; s10 0→5 borrows m1; m1 0→9 borrows m10.
  - m10 0→5 borrows h1; h1 0→9 borrows h10.
- On each tick, mode 1: BCD increment with carry.
  - s1 9→0, s10 5→0, m1 9→0, m10 5→0, h1 9→0 each carry into the next digit.
  - Hours never exceed target, so no hour wrap is needed.
- Completion is the tick whose result is terminal (count = 0 in mode 0, count = target in mode 1).
  - RELOAD=0: done=1 next cycle; state → EXPIRED; expired=1 until next valid load or reset.
  - RELOAD=1: done=1 next cycle; stay RUN. The next tick reloads the count instead of counting: preset in mode 0, 0 in mode 1.
  - With RELOAD=1, the terminal value is displayed for one full second.
- Target of zero in mode 1, or preset of zero in mode 0: start is ignored and the block stays IDLE.
- Reset mid-run: all state returns to reset values on the next edge. No done pulse is produced.

## Timing

- All outputs are registered.
- load → time_out, expired, load_err update on the next edge (1-cycle latency).
- start → running=1 one cycle later.
- From IDLE, the first tick lands TICK_DIV cycles after the start edge, and time_out changes on that edge.
- done rises on the same edge that time_out shows the terminal value and lasts exactly one cycle.
- Pause/resume: total RUN cycles between ticks is always TICK_DIV; the fractional second is preserved across pause.
- A load in the same cycle as a tick: the load wins and the tick is discarded.

## Test plan

All tests use TICK_DIV=4, HR_MAX=99.

1. Down-count to expiry.
   - Stimulus: reset; load 32'h00F01F05 with mode 0; start.
   - Response: time_out 00F01F04 four cycles after running rises. After 65 ticks (260 RUN cycles): time_out 00F00F00, done pulses once, expired=1, running=0.
2. Borrow chain.
   - Stimulus: load 32'h01F00F00; start.
   - Response: after one tick time_out = 32'h00F59F59.
3. Pause/resume.
   - Stimulus: load 00F00F03; start; pause 2 cycles after start; hold 10 cycles; start again.
   - Response: count frozen at 03 during pause. First tick lands 2 cycles after resume.
4. Invalid load.
   - Stimulus: load 32'h00F00F6A, then 32'hA0F00F00.
   - Response: load_err pulses each time; time_out and state unchanged.
5. Up mode with RELOAD=1.
   - Stimulus: load target 00F00F03 with mode 1; start.
   - Response: time_out sequence 00, 01, 02, 03 (done), 00, 01, … with done every 4 ticks. expired stays 0.
6. Priority and reset.
   - Stimulus: load and start in the same cycle; then start alone.
   - Response: first start ignored, state IDLE; second start runs.
   - Stimulus: rst_n low mid-run.
   - Response: next edge gives time_out 00F00F00, running=0, no done pulse.

Source files
------------

// File: rtl/bcd_timer.sv
// bcd_timer: BCD hh:mm:ss timer. Counts down from a loaded preset to zero
// (mode 0) or up from zero to a loaded target (mode 1). Load/start/pause
// control, preset validation, one-cycle done pulse, sticky expired flag and
// optional auto-reload. The packed time word matches the 7-segment driver:
// {h10,h1,4'hF,m10,m1,4'hF,s10,s1}.
//
// Ports:
//   clk       system clock
//   rst_n     synchronous active-low reset
//   load      pulse: capture preset + mode, enter IDLE (rejected if invalid)
//   preset    packed BCD preset/target, separator nibbles ignored
//   mode      0 = count down, 1 = count up (sampled on load only)
//   start     pulse: begin or resume counting
//   pause     pulse: suspend counting
//   time_out  current count, separators forced to 4'hF
//   running   high while in RUN
//   done      one-cycle pulse on completion
//   expired   sticky completion flag (RELOAD=0)
//   load_err  one-cycle pulse when a load is rejected
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | loaded (or reset), waiting for start
// RUN      | prescaler advancing, count updated on each tick
// PAUSE    | count and prescaler frozen, start resumes
// EXPIRED  | completion reached with RELOAD=0, only a load leaves it

module bcd_timer #(
   parameter int unsigned TICK_DIV = 100000000,
   parameter int unsigned HR_MAX   = 99,
   parameter bit          RELOAD   = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [31:0] preset,
   input  logic        mode,
   input  logic        start,
   input  logic        pause,
   output logic [31:0] time_out,
   output logic        running,
   output logic        done,
   output logic        expired,
   output logic        load_err
);

   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_PAUSE,
      ST_EXPIRED
   } state_t;

   state_t        state, state_nxt;
   // count/target hold six digits {h10,h1,m10,m1,s10,s1}
   logic [23:0]   count, count_nxt;
   logic [23:0]   target, target_nxt;
   logic          mode_lat, mode_lat_nxt;
   // prescaler is a down-counter; TICK_DIV-1 means "no RUN cycles elapsed yet"
   logic [PW-1:0] presc, presc_nxt;
   logic          reload_pend, reload_pend_nxt;
   logic          done_nxt, load_err_nxt;

   logic [23:0]   preset_digits;
   logic [23:0]   count_step;
   logic          preset_ok;
   logic          cur_terminal;
   logic          step_terminal;
   logic          tick;
   logic          unused_sep;

   function automatic logic [23:0] bcd_dec(input logic [23:0] t);
      logic [23:0] r;
      r = t;
      if (t[3:0] != 4'd0) r[3:0] = t[3:0] - 4'd1;
      else begin
         r[3:0] = 4'd9;
         if (t[7:4] != 4'd0) r[7:4] = t[7:4] - 4'd1;
         else begin
            r[7:4] = 4'd5;
            if (t[11:8] != 4'd0) r[11:8] = t[11:8] - 4'd1;
            else begin
               r[11:8] = 4'd9;
               if (t[15:12] != 4'd0) r[15:12] = t[15:12] - 4'd1;
               else begin
                  r[15:12] = 4'd5;
                  if (t[19:16] != 4'd0) r[19:16] = t[19:16] - 4'd1;
                  else begin
                     r[19:16] = 4'd9;
                     r[23:20] = t[23:20] - 4'd1;
                  end
               end
            end
         end
      end
      return r;
   endfunction

   // Hours never pass the target, so h10 needs no wrap.
   function automatic logic [23:0] bcd_inc(input logic [23:0] t);
      logic [23:0] r;
      r = t;
      if (t[3:0] != 4'd9) r[3:0] = t[3:0] + 4'd1;
      else begin
         r[3:0] = 4'd0;
         if (t[7:4] != 4'd5) r[7:4] = t[7:4] + 4'd1;
         else begin
            r[7:4] = 4'd0;
            if (t[11:8] != 4'd9) r[11:8] = t[11:8] + 4'd1;
            else begin
               r[11:8] = 4'd0;
               if (t[15:12] != 4'd5) r[15:12] = t[15:12] + 4'd1;
               else begin
                  r[15:12] = 4'd0;
                  if (t[19:16] != 4'd9) r[19:16] = t[19:16] + 4'd1;
                  else begin
                     r[19:16] = 4'd0;
                     r[23:20] = t[23:20] + 4'd1;
                  end
               end
            end
         end
      end
      return r;
   endfunction

   function automatic logic preset_valid(input logic [31:0] p);
      int unsigned hrs;
      logic        ok;
      hrs = 32'(p[31:28]) * 32'd10 + 32'(p[27:24]);
      ok  = (p[31:28] <= 4'd9) && (p[27:24] <= 4'd9) &&
            (p[19:16] <= 4'd5) && (p[15:12] <= 4'd9) &&
            (p[7:4]   <= 4'd5) && (p[3:0]   <= 4'd9) &&
            (hrs <= HR_MAX);
      return ok;
   endfunction

   assign unused_sep    = ^{preset[23:20], preset[11:8]};
   assign preset_digits = {preset[31:24], preset[19:12], preset[7:0]};
   assign preset_ok     = preset_valid(preset);

   assign tick          = (state == ST_RUN) && (presc == '0);
   assign count_step    = mode_lat ? bcd_inc(count) : bcd_dec(count);
   assign cur_terminal  = mode_lat ? (count == target) : (count == 24'd0);
   assign step_terminal = mode_lat ? (count_step == target) : (count_step == 24'd0);

   always_comb begin
      state_nxt       = state;
      count_nxt       = count;
      target_nxt      = target;
      mode_lat_nxt    = mode_lat;
      presc_nxt       = presc;
      reload_pend_nxt = reload_pend;
      done_nxt        = 1'b0;
      load_err_nxt    = 1'b0;

      // Counting happens first; control below may override it.
      if (state == ST_RUN) begin
         if (tick) begin
            presc_nxt = PRESC_TOP;
            if (reload_pend) begin
               // terminal value has been shown for a full second, restart
               count_nxt       = mode_lat ? 24'd0 : target;
               reload_pend_nxt = 1'b0;
            end else begin
               count_nxt = count_step;
               if (step_terminal) begin
                  done_nxt = 1'b1;
                  if (RELOAD) reload_pend_nxt = 1'b1;
                  else        state_nxt       = ST_EXPIRED;
               end
            end
         end else begin
            presc_nxt = presc - 1'b1;
         end
      end

      if (load) begin
         // A rejected load only flags the error; counting carries on.
         if (preset_ok) begin
            target_nxt      = preset_digits;
            count_nxt       = mode ? 24'd0 : preset_digits;
            mode_lat_nxt    = mode;
            presc_nxt       = PRESC_TOP;
            reload_pend_nxt = 1'b0;
            done_nxt        = 1'b0;
            state_nxt       = ST_IDLE;
         end else begin
            load_err_nxt = 1'b1;
         end
      end else if (pause && state == ST_RUN) begin
         // a completing tick on the same edge still wins into EXPIRED
         if (state_nxt == ST_RUN) state_nxt = ST_PAUSE;
      end else if (start) begin
         if (state == ST_IDLE && !cur_terminal) begin
            state_nxt = ST_RUN;
            presc_nxt = PRESC_TOP;
         end else if (state == ST_PAUSE && (!cur_terminal || reload_pend)) begin
            // paused while showing the terminal value before a reload
            state_nxt = ST_RUN;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         count       <= 24'd0;
         target      <= 24'd0;
         mode_lat    <= 1'b0;
         presc       <= PRESC_TOP;
         reload_pend <= 1'b0;
         running     <= 1'b0;
         done        <= 1'b0;
         expired     <= 1'b0;
         load_err    <= 1'b0;
      end else begin
         state       <= state_nxt;
         count       <= count_nxt;
         target      <= target_nxt;
         mode_lat    <= mode_lat_nxt;
         presc       <= presc_nxt;
         reload_pend <= reload_pend_nxt;
         running     <= (state_nxt == ST_RUN);
         done        <= done_nxt;
         expired     <= (state_nxt == ST_EXPIRED);
         load_err    <= load_err_nxt;
      end
   end

   assign time_out = {count[23:16], 4'hF, count[15:8], 4'hF, count[7:0]};

endmodule

// File: tb/tb_bcd_timer.sv
// tb_bcd_timer: directed, table-driven bench for bcd_timer with TICK_DIV=4,
// HR_MAX=99. dut0 uses RELOAD=0, dut1 uses RELOAD=1; both share stimulus.
module tb_bcd_timer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load;
   logic [31:0] preset;
   logic        mode;
   logic        start;
   logic        pause;

   logic [31:0] time0, time1;
   logic        running0, running1;
   logic        done0, done1;
   logic        expired0, expired1;
   logic        load_err0, load_err1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bcd_timer #(.TICK_DIV(4), .HR_MAX(99), .RELOAD(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .load(load), .preset(preset), .mode(mode),
      .start(start), .pause(pause), .time_out(time0), .running(running0),
      .done(done0), .expired(expired0), .load_err(load_err0)
   );

   bcd_timer #(.TICK_DIV(4), .HR_MAX(99), .RELOAD(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .load(load), .preset(preset), .mode(mode),
      .start(start), .pause(pause), .time_out(time1), .running(running1),
      .done(done1), .expired(expired1), .load_err(load_err1)
   );

   typedef struct {
      logic [31:0] preset;
      logic        mode;
      logic        exp_err;
      logic [31:0] exp_time;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic l, input logic [31:0] p, input logic m,
                        input logic s, input logic ps);
      load   = l;
      preset = p;
      mode   = m;
      start  = s;
      pause  = ps;
      step();
      load  = 1'b0;
      start = 1'b0;
      pause = 1'b0;
   endtask

   initial begin
      int done_cnt;
      int done_at;
      logic [31:0] time_at_done;
      logic frozen_ok;
      logic side_ok;

      rst_n = 1'b0; load = 1'b0; preset = '0; mode = 1'b0; start = 1'b0; pause = 1'b0;

      vecs[0] = '{32'h00F01F05, 1'b0, 1'b0, 32'h00F01F05};
      vecs[1] = '{32'h00F00F6A, 1'b0, 1'b1, 32'h00F01F05};
      vecs[2] = '{32'hA0F00F00, 1'b0, 1'b1, 32'h00F01F05};
      vecs[3] = '{32'h99F59F59, 1'b0, 1'b0, 32'h99F59F59};
      vecs[4] = '{32'h00F60F00, 1'b0, 1'b1, 32'h99F59F59};
      vecs[5] = '{32'h12F34F56, 1'b1, 1'b0, 32'h00F00F00};
      vecs[6] = '{32'h00F00F00, 1'b0, 1'b0, 32'h00F00F00};
      vecs[7] = '{32'h05F0AF00, 1'b0, 1'b1, 32'h00F00F00};
      vecs[8] = '{32'h01023045, 1'b0, 1'b0, 32'h01F23F45};

      step(); step();
      rst_n = 1'b1;
      chk("reset time_out", time0, 32'h00F00F00);
      chk("reset running", {31'd0, running0}, 32'd0);
      chk("reset done", {31'd0, done0}, 32'd0);
      chk("reset expired", {31'd0, expired0}, 32'd0);
      chk("reset load_err", {31'd0, load_err0}, 32'd0);
      chk("reset time_out r1", time1, 32'h00F00F00);

      // load validation table
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, vecs[i].preset, vecs[i].mode, 1'b0, 1'b0);
         chk($sformatf("vec%0d load_err", i), {31'd0, load_err0}, {31'd0, vecs[i].exp_err});
         chk($sformatf("vec%0d time_out", i), time0, vecs[i].exp_time);
         chk($sformatf("vec%0d running", i), {31'd0, running0}, 32'd0);
         step();
         chk($sformatf("vec%0d load_err clears", i), {31'd0, load_err0}, 32'd0);
      end

      // down-count to expiry
      drive(1'b1, 32'h00F01F05, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 32'h00F01F05, 1'b0, 1'b1, 1'b0);
      chk("t1 running after start", {31'd0, running0}, 32'd1);
      step(); step(); step();
      chk("t1 no tick before 4 cycles", time0, 32'h00F01F05);
      step();
      chk("t1 first tick", time0, 32'h00F01F04);
      done_cnt = 0; done_at = -1; time_at_done = '0;
      for (int i = 1; i <= 300; i++) begin
         step();
         if (done0) begin
            done_cnt++;
            if (done_at < 0) begin
               done_at = i;
               time_at_done = time0;
            end
         end
      end
      chk("t1 done pulse count", done_cnt, 1);
      chk("t1 done cycle", done_at, 256);
      chk("t1 time at done", time_at_done, 32'h00F00F00);
      chk("t1 expired", {31'd0, expired0}, 32'd1);
      chk("t1 running", {31'd0, running0}, 32'd0);
      drive(1'b0, 32'h00F01F05, 1'b0, 1'b1, 1'b0);
      chk("t1 start ignored in expired", {31'd0, running0}, 32'd0);

      // borrow chain
      drive(1'b1, 32'h01F00F00, 1'b0, 1'b0, 1'b0);
      chk("t2 load clears expired", {31'd0, expired0}, 32'd0);
      drive(1'b0, 32'h01F00F00, 1'b0, 1'b1, 1'b0);
      step(); step(); step(); step();
      chk("t2 borrow chain", time0, 32'h00F59F59);

      // pause / resume
      drive(1'b1, 32'h00F00F03, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 32'h00F00F03, 1'b0, 1'b1, 1'b0);
      step();
      drive(1'b0, 32'h00F00F03, 1'b0, 1'b0, 1'b1);
      chk("t3 running after pause", {31'd0, running0}, 32'd0);
      frozen_ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         if (time0 !== 32'h00F00F03 || running0 !== 1'b0) frozen_ok = 1'b0;
      end
      chk("t3 frozen during pause", {31'd0, frozen_ok}, 32'd1);
      drive(1'b0, 32'h00F00F03, 1'b0, 1'b1, 1'b0);
      chk("t3 resumed", {31'd0, running0}, 32'd1);
      step();
      chk("t3 no tick 1 after resume", time0, 32'h00F00F03);
      step();
      chk("t3 tick 2 after resume", time0, 32'h00F00F02);

      // priority: load beats start, then reset mid-run
      drive(1'b1, 32'h00F00F02, 1'b0, 1'b1, 1'b0);
      chk("t6 load+start stays idle", {31'd0, running0}, 32'd0);
      step();
      chk("t6 still idle", {31'd0, running0}, 32'd0);
      chk("t6 loaded value", time0, 32'h00F00F02);
      drive(1'b0, 32'h00F00F02, 1'b0, 1'b1, 1'b0);
      chk("t6 second start runs", {31'd0, running0}, 32'd1);
      for (int i = 0; i < 7; i++) step();
      chk("t6 before reset", time0, 32'h00F00F01);
      rst_n = 1'b0;
      step();
      chk("t6 reset time_out", time0, 32'h00F00F00);
      chk("t6 reset running", {31'd0, running0}, 32'd0);
      chk("t6 reset no done", {31'd0, done0}, 32'd0);
      chk("t6 reset expired", {31'd0, expired0}, 32'd0);
      rst_n = 1'b1;
      step();

      // zero preset in mode 0: start ignored
      drive(1'b0, 32'h00F00F00, 1'b0, 1'b1, 1'b0);
      chk("zero preset start ignored", {31'd0, running0}, 32'd0);

      // up mode with auto-reload (dut1)
      drive(1'b1, 32'h00F00F03, 1'b1, 1'b0, 1'b0);
      chk("t5 load up mode", time1, 32'h00F00F00);
      drive(1'b0, 32'h00F00F03, 1'b1, 1'b1, 1'b0);
      chk("t5 running", {31'd0, running1}, 32'd1);
      side_ok = 1'b1;
      for (int i = 1; i <= 32; i++) begin
         step();
         if (i % 4 == 0) begin
            chk($sformatf("t5 tick%0d time", i / 4), time1,
                {24'h00F00F, 4'd0, 4'((i / 4) % 4)});
            chk($sformatf("t5 tick%0d done", i / 4), {31'd0, done1},
                {31'd0, ((i / 4) % 4) == 3});
         end else if (done1 !== 1'b0) begin
            side_ok = 1'b0;
         end
         if (expired1 !== 1'b0 || running1 !== 1'b1) side_ok = 1'b0;
      end
      chk("t5 no stray done, no expiry, stays running", {31'd0, side_ok}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
